// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode handshake bundle: push side from fetch, pop side to decode, plus flush.
interface fetch_decode_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc8;
  logic [4:0]  out_exc;
  logic [1:0]  count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_pc8, out_exc, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_pc8, out_exc, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Two-entry fetch->decode queue: stores {pc, instr, pc+8, exc}, tags fetch address errors,
// absorbs one cycle of decode back-pressure and is emptied by a redirect flush.
module fetch_decode_queue #(
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input logic                  clk,
  input logic                  reset,
  fetch_decode_queue_if.slave  q_io
);

  localparam logic [31:0] ImLimit = IM_BASE + 32'(4 * IM_WORDS);

  logic [1:0][31:0] pc_q, pc_d;
  logic [1:0][31:0] instr_q, instr_d;
  logic [1:0][31:0] pc8_q, pc8_d;
  logic [1:0][4:0]  exc_q, exc_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;

  logic       push, pop, out_valid, in_fault;
  logic [4:0] in_exc;

  assign out_valid = (count_q != 2'd0);
  assign push      = q_io.in_valid & q_io.in_ready & ~q_io.flush;
  assign pop       = out_valid & q_io.out_ready;

  assign in_fault = (q_io.in_pc[1:0] != 2'b00) || (q_io.in_pc < IM_BASE) ||
                    (q_io.in_pc >= ImLimit);
  assign in_exc   = in_fault ? EXC_ADEL : 5'd0;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc8_d    = pc8_q;
    exc_d    = exc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (q_io.flush) begin
      pc_d     = '0;
      instr_d  = '0;
      pc8_d    = '0;
      exc_d    = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]    = q_io.in_pc;
        instr_d[wr_ptr_q] = in_fault ? 32'h0 : q_io.in_instr;
        pc8_d[wr_ptr_q]   = q_io.in_pc + 32'd8;
        exc_d[wr_ptr_q]   = in_exc;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      instr_q  <= '0;
      pc8_q    <= '0;
      exc_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc8_q    <= pc8_d;
      exc_q    <= exc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Outputs come only from registered head state; empty queue reads as all zeros.
  assign q_io.in_ready  = (count_q != 2'd2);
  assign q_io.out_valid = out_valid;
  assign q_io.out_pc    = out_valid ? pc_q[rd_ptr_q]    : 32'h0;
  assign q_io.out_instr = out_valid ? instr_q[rd_ptr_q] : 32'h0;
  assign q_io.out_pc8   = out_valid ? pc8_q[rd_ptr_q]   : 32'h0;
  assign q_io.out_exc   = out_valid ? exc_q[rd_ptr_q]   : 5'd0;
  assign q_io.count     = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: reset, push/pop, back-pressure, flush, address errors.
module tb_fetch_decode_queue;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fetch_decode_queue_if bus ();

  fetch_decode_queue dut (
    .clk  (clk),
    .reset(reset),
    .q_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and outputs are then handled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_pc     = 32'h0;
    bus.in_instr  = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check_val({tag, "_count"}, 32'(bus.count), 32'd0);
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_pc"}, bus.out_pc, 32'h0);
    check_val({tag, "_instr"}, bus.out_instr, 32'h0);
    check_val({tag, "_pc8"}, bus.out_pc8, 32'h0);
    check_val({tag, "_exc"}, 32'(bus.out_exc), 32'd0);
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc8, input logic [4:0] exc);
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, "_pc"}, bus.out_pc, pc);
    check_val({tag, "_instr"}, bus.out_instr, instr);
    check_val({tag, "_pc8"}, bus.out_pc8, pc8);
    check_val({tag, "_exc"}, 32'(bus.out_exc), 32'(exc));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_empty("reset");

    // Single push with decode stalled
    push_one(32'h3000, 32'h3c01_0001);
    check_head("single", 32'h3000, 32'h3c01_0001, 32'h3008, 5'd0);
    check_val("single_count", 32'(bus.count), 32'd1);

    // Fill, then an in_valid while full must be dropped
    push_one(32'h3004, 32'h2402_0005);
    check_val("full_count", 32'(bus.count), 32'd2);
    check_val("full_in_ready", 32'(bus.in_ready), 32'd0);
    check_head("full_head", 32'h3000, 32'h3c01_0001, 32'h3008, 5'd0);
    push_one(32'h3008, 32'h1111_1111);
    check_val("drop_count", 32'(bus.count), 32'd2);
    check_head("stall_head", 32'h3000, 32'h3c01_0001, 32'h3008, 5'd0);
    pop_one();
    check_head("pop_head", 32'h3004, 32'h2402_0005, 32'h300c, 5'd0);
    check_val("pop_count", 32'(bus.count), 32'd1);
    check_val("pop_in_ready", 32'(bus.in_ready), 32'd1);
    pop_one();
    check_empty("drained");

    // Simultaneous push and pop at count=1
    push_one(32'h3000, 32'hAAAA_0000);
    bus.out_ready = 1'b1;
    push_one(32'h3004, 32'hBBBB_0000);
    bus.out_ready = 1'b0;
    check_val("pp_count", 32'(bus.count), 32'd1);
    check_head("pp_head", 32'h3004, 32'hBBBB_0000, 32'h300c, 5'd0);
    pop_one();
    check_val("pp_drain_count", 32'(bus.count), 32'd0);

    // Flush from full with incoming push and pop requested
    push_one(32'h3000, 32'h0000_0001);
    push_one(32'h3004, 32'h0000_0002);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h3008;
    bus.in_instr  = 32'h0000_0003;
    bus.out_ready = 1'b1;
    step();
    idle_inputs();
    check_empty("flush_full");
    step();
    check_empty("flush_after");

    // Flush at count=1 where the incoming push would otherwise be accepted
    push_one(32'h3010, 32'h0000_0004);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h3014;
    step();
    idle_inputs();
    check_empty("flush_one");

    // Address errors
    push_one(32'h3002, 32'h1234_5678);
    check_head("misalign", 32'h3002, 32'h0, 32'h300a, 5'd4);
    pop_one();
    push_one(32'h7000, 32'h1234_5678);
    check_head("above", 32'h7000, 32'h0, 32'h7008, 5'd4);
    pop_one();
    push_one(32'h6ffc, 32'h1234_5678);
    check_head("last_word", 32'h6ffc, 32'h1234_5678, 32'h7004, 5'd0);
    pop_one();
    push_one(32'h2ffc, 32'h1234_5678);
    check_head("below", 32'h2ffc, 32'h0, 32'h3004, 5'd4);
    pop_one();
    push_one(32'hffff_fffc, 32'h1234_5678);
    check_head("wrap_pc8", 32'hffff_fffc, 32'h0, 32'h0000_0004, 5'd4);
    pop_one();
    check_val("err_drain_count", 32'(bus.count), 32'd0);

    // Reset mid-operation dominates a concurrent flush/push
    push_one(32'h3020, 32'h0000_0005);
    push_one(32'h3024, 32'h0000_0006);
    reset        = 1'b1;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h3028;
    step();
    reset = 1'b0;
    idle_inputs();
    check_empty("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Two-entry instruction queue between the fetch unit and the decode stage of the pipelined MIPS core.
- Captures each fetched {PC, instruction} pair, computes its link address PC+8, and tags address-error fetches.
- Presents one entry per cycle to decode under a valid/ready handshake.
- Absorbs one cycle of decode back-pressure without stalling fetch, and is emptied by a branch/jump redirect flush.

Parameters:
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_WORDS, 4096, number of 32-bit words in instruction memory.
- EXC_ADEL, 5'd4, exception code written for an instruction-fetch address error.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  output  1  queue can accept a push this cycle.
- in_pc  input  32  PC of fetched instruction.
- in_instr  input  32  fetched instruction word.
- flush  input  1  redirect: discard all queued and incoming entries.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  32  head PC.
- out_instr  output  32  head instruction (0 = nop when invalid or faulted).
- out_pc8  output  32  head PC + 8, link address for jal/jalr.
- out_exc  output  5  head exception code, 0 = none.
- count  output  2  current occupancy, 0..2.

Behaviour:
- Reset has clk as clock and reset as synchronous, active-high reset. On reset: count=0, both entries cleared, out_valid=0, out_pc/out_instr/out_pc8/out_exc=0, in_ready=1.
- Storage: 2-entry circular buffer with 1-bit read pointer, 1-bit write pointer and 2-bit count.
- Outputs are driven from the head entry, with no combinational path from in_* to out_*.
- in_ready = (count != 2). It is combinational from state only and does not depend on out_ready.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
- When out_valid=0, out_pc, out_instr, out_pc8 and out_exc all read 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; the head advances and the new entry lands in the tail.
  - At count=2, in_ready=0, so push and pop cannot coincide; a pop drops count to 1.
- Pointers wrap modulo 2.
- Flush has highest priority after reset. Any same-cycle push and pop are ignored, and count, pointers and entries are zeroed at the next edge, so out_valid=0 in the following cycle. The flush cycle's in_* entry is never stored.
- Exception tagging happens on push:
  - exc = EXC_ADEL if in_pc[1:0] != 0, or in_pc < IM_BASE, or in_pc >= IM_BASE + 4*IM_WORDS; otherwise exc = 0.
  - When exc != 0, the stored instruction is forced to 32'h0 and the stored PC keeps the faulting in_pc.
- pc8 is stored as in_pc + 8 using 32-bit wrap-around arithmetic. It is computed for faulted entries as well.
- Decode stall: holding out_ready=0 keeps the head's out_* values stable every cycle until it is popped or flushed.
- Reset mid-operation: queued entries are lost and the state returns to the reset values above at that edge; reset dominates flush.
- Pushing while count=2 is not possible because in_ready=0. Fetch must hold its PC; an in_valid asserted while in_ready=0 has no effect.
- Popping while count=0 has no effect, since out_valid=0.

Test Plan:
- Reset then idle: reset high 2 cycles -> count=0, out_valid=0, in_ready=1, all out_* = 0.
- Single push: in_pc=0x3000, in_instr=0x3c010001 for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_pc=0x3000, out_instr=0x3c010001, out_pc8=0x3008, out_exc=0, count=1.
- Fill and back-pressure:
  - Stimulus: push 0x3000 then 0x3004 with out_ready=0.
  - Required: count=2 and in_ready=0, the head stays at 0x3000, and in_valid on 0x3008 is dropped.
  - Then out_ready=1 for 1 cycle -> head=0x3004, count=1, in_ready=1.
- Simultaneous push/pop at count=1: head 0x3000, push 0x3004 with out_ready=1 -> next cycle count=1, out_pc=0x3004, in order.
- Flush:
  - Stimulus: count=2 (0x3000, 0x3004); flush=1 together with in_valid on 0x3008 and out_ready=1.
  - Required: next cycle count=0, out_valid=0, all out_*=0, and 0x3008 is never presented.
- Address errors:
  - push in_pc=0x3002, in_instr=0x12345678 -> out_exc=4, out_instr=0, out_pc=0x3002, out_pc8=0x300a.
  - push 0x7000 -> out_exc=4.
  - push 0x6ffc -> out_exc=0.
  - push 0x2ffc -> out_exc=4.
